// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port byte-addressed data memory between the fetch (I) port
// and the load/store (D) port. Every access runs IDLE -> ACCESS -> RESP; a request that fails
// the size/alignment/range check skips ACCESS and answers with an error one cycle later.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES    = 4096,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_offset,
    output logic        mem_unsigned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [2:0] SizeWord = 3'b100;
    localparam logic [2:0] SizeHalf = 3'b010;
    localparam logic [2:0] SizeByte = 3'b001;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          state_q;
    logic [CntW-1:0] starve_q;

    // Latched request; owner_q = 1 means the D port owns the access in flight.
    logic        owner_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        mem_read_q;
    logic        mem_write_q;
    logic        i_rsp_valid_q;
    logic        i_rsp_err_q;
    logic [31:0] i_rsp_data_q;
    logic        d_rsp_valid_q;
    logic        d_rsp_err_q;
    logic [31:0] d_rsp_data_q;

    logic        starved;
    logic        grant_i;
    logic        grant_d;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic        sel_uns;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  nbytes;
    logic        bad_size;
    logic        misaligned;
    logic [32:0] end_addr;
    logic        sel_err;

    // Arbitration: D wins by default, I wins once it has been passed over STARVE_LIMIT times.
    always_comb begin
        starved = (starve_q == CntW'(STARVE_LIMIT));
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == StIdle) begin
            if (i_req_valid && (starved || !d_req_valid)) begin
                grant_i = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // Request mux and legality check; the end address is formed in 33 bits so it cannot wrap.
    always_comb begin
        sel_we     = grant_d ? d_we       : 1'b0;
        sel_size   = grant_d ? d_size     : SizeWord;
        sel_uns    = grant_d ? d_unsigned : 1'b1;
        sel_addr   = grant_d ? d_addr     : i_addr;
        sel_wdata  = grant_d ? d_wdata    : 32'd0;
        bad_size   = 1'b0;
        misaligned = 1'b0;
        nbytes     = 3'd1;
        case (sel_size)
            SizeWord: begin
                nbytes     = 3'd4;
                misaligned = (sel_addr[1:0] != 2'b00);
            end
            SizeHalf: begin
                nbytes     = 3'd2;
                misaligned = sel_addr[0];
            end
            SizeByte: nbytes = 3'd1;
            default:  bad_size = 1'b1;
        endcase
        end_addr = {1'b0, sel_addr} + {30'd0, nbytes} - 33'd1;
        sel_err  = bad_size || misaligned || (end_addr >= 33'(MEM_BYTES));
    end

    // Access sequencer with registered memory strobes and response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            starve_q      <= '0;
            owner_q       <= 1'b0;
            we_q          <= 1'b0;
            size_q        <= 3'b000;
            uns_q         <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            i_rsp_valid_q <= 1'b0;
            i_rsp_err_q   <= 1'b0;
            i_rsp_data_q  <= 32'd0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_err_q   <= 1'b0;
            d_rsp_data_q  <= 32'd0;
        end else begin
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!i_req_valid || grant_i) begin
                        starve_q <= '0;
                    end else if (grant_d && !starved) begin
                        starve_q <= starve_q + 1'b1;
                    end
                    if (grant_i || grant_d) begin
                        owner_q <= grant_d;
                        we_q    <= sel_we;
                        size_q  <= sel_size;
                        uns_q   <= sel_uns;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (sel_err) begin
                            // Illegal request: never touches memory.
                            state_q <= StResp;
                            if (grant_d) begin
                                d_rsp_valid_q <= 1'b1;
                                d_rsp_err_q   <= 1'b1;
                                d_rsp_data_q  <= 32'd0;
                            end else begin
                                i_rsp_valid_q <= 1'b1;
                                i_rsp_err_q   <= 1'b1;
                                i_rsp_data_q  <= 32'd0;
                            end
                        end else begin
                            state_q     <= StAccess;
                            mem_read_q  <= !sel_we;
                            mem_write_q <= sel_we;
                        end
                    end
                end
                StAccess: begin
                    state_q <= StResp;
                    if (owner_q) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rsp_err_q   <= 1'b0;
                        d_rsp_data_q  <= we_q ? 32'd0 : mem_rdata;
                    end else begin
                        i_rsp_valid_q <= 1'b1;
                        i_rsp_err_q   <= 1'b0;
                        i_rsp_data_q  <= mem_rdata;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_offset   = size_q;
    assign mem_unsigned = uns_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign i_rsp_valid  = i_rsp_valid_q;
    assign i_rsp_err    = i_rsp_err_q;
    assign i_rsp_data   = i_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_err    = d_rsp_err_q;
    assign d_rsp_data   = d_rsp_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory on the mem_* pins, a vector table of directed
// accesses, hand-written multi-cycle sequences and random traffic checked against a shadow model.
module tb_dmem_arbiter;

    localparam int unsigned MemBytes = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_unsigned, d_rsp_valid, d_rsp_err;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic        mem_read, mem_write, mem_unsigned;
    logic [2:0]  mem_offset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(MemBytes), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_offset(mem_offset),
        .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural memory: combinational read with extension, write on posedge, no reset.
    logic [7:0]  ram [MemBytes] = '{default: 8'h00};
    logic [11:0] ma;
    logic [15:0] rh;
    always_comb begin
        ma        = mem_addr[11:0];
        rh        = {ram[ma + 12'd1], ram[ma]};
        mem_rdata = 32'd0;
        case (mem_offset)
            3'b100:  mem_rdata = {ram[ma + 12'd3], ram[ma + 12'd2], ram[ma + 12'd1], ram[ma]};
            3'b010:  mem_rdata = mem_unsigned ? {16'd0, rh} : {{16{rh[15]}}, rh};
            3'b001:  mem_rdata = mem_unsigned ? {24'd0, ram[ma]} : {{24{ram[ma][7]}}, ram[ma]};
            default: mem_rdata = 32'd0;
        endcase
    end
    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_offset)
                3'b100: begin
                    ram[mem_addr[11:0]]         <= mem_wdata[7:0];
                    ram[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
                    ram[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                    ram[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
                end
                3'b010: begin
                    ram[mem_addr[11:0]]         <= mem_wdata[7:0];
                    ram[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
                end
                3'b001:  ram[mem_addr[11:0]] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Event counters sampled on the edge that ends each cycle.
    int strobe_cnt = 0;
    int i_pulse_cnt = 0;
    int d_pulse_cnt = 0;
    always @(posedge clk) begin
        if (mem_read || mem_write) strobe_cnt <= strobe_cnt + 1;
        if (i_rsp_valid) i_pulse_cnt <= i_pulse_cnt + 1;
        if (d_rsp_valid) d_pulse_cnt <= d_pulse_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-array memory plus the legality rules, in plain arithmetic.
    logic [7:0] shadow [MemBytes] = '{default: 8'h00};

    function automatic void model(input logic we, input logic [2:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] data);
        int unsigned nb;
        longint unsigned last;
        longint unsigned v;
        nb   = (size == 3'b100) ? 4 : (size == 3'b010) ? 2 : (size == 3'b001) ? 1 : 0;
        data = 32'd0;
        if (nb == 0) begin
            err = 1'b1;
        end else begin
            last = {32'd0, addr} + nb - 1;
            err  = ((addr % nb) != 0) || (last >= MemBytes);
        end
        if (!err) begin
            if (we) begin
                for (int b = 0; b < int'(nb); b++) shadow[int'(addr) + b] = wdata[8*b +: 8];
            end else begin
                v = 0;
                for (int b = 0; b < int'(nb); b++) v = v | (64'(shadow[int'(addr) + b]) << (8*b));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | (64'hFFFF_FFFF << (8*nb));
                data = v[31:0];
            end
        end
    endfunction

    // One isolated transaction on either port, with timing/strobe/port-isolation checks.
    task automatic txn(input logic is_i, input logic we, input logic [2:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input string tag, output logic got_err, output logic [31:0] got_data,
                       output logic exp_err, output logic [31:0] exp_data);
        int n, lat, s0, o0;
        logic e_we, e_uns;
        logic [2:0] e_size;
        e_we   = is_i ? 1'b0 : we;
        e_size = is_i ? 3'b100 : size;
        e_uns  = is_i ? 1'b1 : uns;
        model(e_we, e_size, e_uns, addr, wdata, exp_err, exp_data);
        got_err  = 1'b1;
        got_data = 32'd0;
        @(negedge clk);
        if (is_i) begin
            i_req_valid = 1'b1; i_addr = addr;
        end else begin
            d_req_valid = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
            d_addr = addr; d_wdata = wdata;
        end
        #1;
        n = 0;
        while (!(is_i ? i_req_ready : d_req_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_ready_wait"}, n, 0);
        if (n >= 20) begin
            i_req_valid = 1'b0; d_req_valid = 1'b0;
            return;
        end
        s0 = strobe_cnt;
        o0 = is_i ? d_pulse_cnt : i_pulse_cnt;
        @(posedge clk); #1;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!(is_i ? i_rsp_valid : d_rsp_valid) && lat < 8);
        got_err  = is_i ? i_rsp_err : d_rsp_err;
        got_data = is_i ? i_rsp_data : d_rsp_data;
        check({tag, "_latency"}, lat, exp_err ? 1 : 2);
        check({tag, "_strobes"}, strobe_cnt - s0, exp_err ? 0 : 1);
        check({tag, "_other_port_rsp"}, is_i ? d_pulse_cnt : i_pulse_cnt, o0);
        check({tag, "_mem_addr"}, mem_addr, addr);
        check({tag, "_mem_offset"}, {29'd0, mem_offset}, {29'd0, e_size});
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        tbl[$];
    logic        ge, ee;
    logic [31:0] gd, ed;
    logic [31:0] bb_addr [3];
    logic        g_port[$];
    int          g_cyc[$];
    int          ng, nr, i_seen, d_seen, p0, sel;
    logic        granted, r_is_i, r_we, r_uns;
    logic [2:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0; i_addr = 32'd0;
        d_req_valid = 1'b0; d_we = 1'b0; d_size = 3'b000; d_unsigned = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_i_rsp_valid", {31'd0, i_rsp_valid}, 0);
        check("reset_d_rsp_valid", {31'd0, d_rsp_valid}, 0);
        check("reset_rsp_err", {30'd0, i_rsp_err, d_rsp_err}, 0);
        check("reset_i_rsp_data", i_rsp_data, 0);
        check("reset_d_rsp_data", d_rsp_data, 0);
        check("reset_mem_strobes", {30'd0, mem_read, mem_write}, 0);
        check("reset_mem_addr", mem_addr, 0);

        // we, size, uns, addr, wdata, err, data
        tbl.push_back('{1'b1, 3'b100, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 32'h10,  32'h0, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 3'b001, 1'b0, 32'h21,  32'h80, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 32'h21,  32'h0, 1'b0, 32'hFFFFFF80});
        tbl.push_back('{1'b0, 3'b001, 1'b1, 32'h21,  32'h0, 1'b0, 32'h00000080});
        tbl.push_back('{1'b1, 3'b010, 1'b0, 32'h22,  32'h8001, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h22,  32'h0, 1'b0, 32'hFFFF8001});
        tbl.push_back('{1'b0, 3'b010, 1'b1, 32'h22,  32'h0, 1'b0, 32'h00008001});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 32'h20,  32'h0, 1'b0, 32'h80018000});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 32'h13,  32'h0, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h41,  32'h0, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 32'hFFE, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 3'b111, 1'b0, 32'h0,   32'h0, 1'b1, 32'h0});
        tbl.push_back('{1'b1, 3'b100, 1'b0, 32'hFFC, 32'h11223344, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h11223344});
        tbl.push_back('{1'b0, 3'b001, 1'b1, 32'hFFF, 32'h0, 1'b0, 32'h00000011});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 32'hFFF, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{1'b1, 3'b100, 1'b0, 32'hFFFFFFFC, 32'h55AA55AA, 1'b1, 32'h0});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 32'h10,  32'h12345678, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 32'h10,  32'h0, 1'b0, 32'hDEADBEEF});

        foreach (tbl[k]) begin
            txn(1'b0, tbl[k].we, tbl[k].size, tbl[k].uns, tbl[k].addr, tbl[k].wdata,
                $sformatf("vec%0d", k), ge, gd, ee, ed);
            check($sformatf("vec%0d_err", k), {31'd0, ge}, {31'd0, tbl[k].exp_err});
            check($sformatf("vec%0d_data", k), gd, tbl[k].exp_data);
        end

        // Fetch port: good fetch, misaligned fetch, fetch at the top word.
        txn(1'b1, 1'b0, 3'b000, 1'b0, 32'h10, 32'h0, "ifetch_10", ge, gd, ee, ed);
        check("ifetch_10_err", {31'd0, ge}, 0);
        check("ifetch_10_data", gd, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 3'b000, 1'b0, 32'h12, 32'h0, "ifetch_12", ge, gd, ee, ed);
        check("ifetch_12_err", {31'd0, ge}, 1);
        check("ifetch_12_data", gd, 0);
        txn(1'b1, 1'b0, 3'b000, 1'b0, 32'hFFC, 32'h0, "ifetch_ffc", ge, gd, ee, ed);
        check("ifetch_ffc_data", gd, 32'h11223344);

        // Starvation: both ports held valid, every 4th grant must go to I.
        @(negedge clk);
        i_req_valid = 1'b1; i_addr = 32'h10;
        d_req_valid = 1'b1; d_we = 1'b0; d_size = 3'b100; d_unsigned = 1'b0; d_addr = 32'h10;
        i_seen = 0; d_seen = 0;
        for (int c = 0; c < 36; c++) begin
            #1;
            if (i_req_ready && d_req_ready) check("starve_both_ready", 1, 0);
            if (i_req_ready || d_req_ready) begin
                g_port.push_back(i_req_ready);
                g_cyc.push_back(c);
            end
            if (i_rsp_valid) begin
                i_seen++;
                check("starve_i_data", i_rsp_data, 32'hDEADBEEF);
            end
            if (d_rsp_valid) begin
                d_seen++;
                check("starve_d_data", d_rsp_data, 32'hDEADBEEF);
            end
            @(negedge clk);
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        check("starve_grant_count", g_port.size(), 12);
        foreach (g_port[k]) begin
            check($sformatf("starve_grant%0d_is_i", k), {31'd0, g_port[k]}, (k % 4 == 3) ? 1 : 0);
            if (k > 0) check($sformatf("starve_grant%0d_gap", k), g_cyc[k] - g_cyc[k-1], 3);
        end
        check("starve_i_rsps", i_seen, 3);
        check("starve_d_rsps", d_seen, 9);

        // Back-to-back loads with d_req_valid held high.
        bb_addr[0] = 32'h10; bb_addr[1] = 32'h20; bb_addr[2] = 32'hFFC;
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b0; d_size = 3'b100; d_unsigned = 1'b0; d_addr = bb_addr[0];
        ng = 0; nr = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            granted = d_req_ready;
            if (granted) begin
                check("b2b_ready_cycle", c, 3 * ng);
                ng++;
            end
            if (d_rsp_valid) begin
                if (nr < 3) begin
                    model(1'b0, 3'b100, 1'b0, bb_addr[nr], 32'h0, ee, ed);
                    check($sformatf("b2b_data%0d", nr), d_rsp_data, ed);
                end
                nr++;
            end
            @(posedge clk); #1;
            if (granted) begin
                if (ng < 3) d_addr = bb_addr[ng];
                else d_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        d_req_valid = 1'b0;
        check("b2b_grants", ng, 3);
        check("b2b_rsps", nr, 3);

        // Reset during the ACCESS cycle of a store: no response, but the store still lands.
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b1; d_size = 3'b100; d_unsigned = 1'b0;
        d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
        #1 check("rstmid_ready", {31'd0, d_req_ready}, 1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        check("rstmid_in_access", {31'd0, mem_write}, 1);
        p0 = d_pulse_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int b = 0; b < 4; b++) shadow[8'h30 + b] = 8'((32'hCAFEF00D >> (8 * b)) & 32'hFF);
        @(negedge clk);
        check("rstmid_strobes", {30'd0, mem_read, mem_write}, 0);
        check("rstmid_rsp_valid", {30'd0, i_rsp_valid, d_rsp_valid}, 0);
        check("rstmid_d_rsp_data", d_rsp_data, 0);
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_mem_wdata", mem_wdata, 0);
        repeat (3) @(negedge clk);
        check("rstmid_no_rsp", d_pulse_cnt, p0);
        txn(1'b0, 1'b0, 3'b100, 1'b0, 32'h30, 32'h0, "rstmid_load", ge, gd, ee, ed);
        check("rstmid_load_data", gd, 32'hCAFEF00D);

        // Random traffic against the shadow model.
        for (int k = 0; k < 80; k++) begin
            r_is_i = ($urandom_range(0, 3) == 0);
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1, 2: r_size = 3'b100;
                3, 4:    r_size = 3'b010;
                5, 6:    r_size = 3'b001;
                default: r_size = 3'($urandom_range(0, 7));
            endcase
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2: r_addr = 32'($urandom_range(0, 63));
                3:       r_addr = 32'(4095 - $urandom_range(0, 7));
                4:       r_addr = 32'($urandom_range(0, 4095));
                default: r_addr = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            r_wdata = $urandom;
            txn(r_is_i, r_we, r_size, r_uns, r_addr, r_wdata, "rand", ge, gd, ee, ed);
            check("rand_err", {31'd0, ge}, {31'd0, ee});
            check("rand_data", gd, ed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
